// File: rtl/contador_ud_mod_pkg.sv
// Shared encodings for the modulo-M up/down counter and the control FSMs that drive it.
// Direction values are what drives desce; mode values are what goes in SATURATE.
package contador_ud_mod_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

endpackage

// File: rtl/contador_ud_mod.sv
// Parametrised modulo-M up/down counter with sync clear/load, wrap or saturate mode,
// combinational terminal count (rco) for cascading, and a sticky overflow flag (estouro).
module contador_ud_mod
    import contador_ud_mod_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MODULO      = 16,
    parameter int SATURATE    = MODE_WRAP,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             carrega,
    input  logic [WIDTH-1:0] D,
    input  logic             conta,
    input  logic             desce,
    input  logic             limpa_flag,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             estouro
);

    if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
        $fatal(1, "contador_ud_mod: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULO) begin : g_bad_reset_value
        $fatal(1, "contador_ud_mod: RESET_VALUE must be below MODULO");
    end

    // Highest legal count; everything is compared at WIDTH bits so MODULO == 2**WIDTH works.
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic             SAT     = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] q_nxt;
    logic             flag_nxt;
    logic             evento;

    always_comb begin
        q_nxt    = Q;
        flag_nxt = estouro;
        evento   = 1'b0;
        if (zera) begin
            q_nxt    = '0;
            flag_nxt = 1'b0;
        end else begin
            if (carrega) begin
                q_nxt = (D > TOP) ? TOP : D;
            end else if (conta) begin
                if (desce == DIR_UP) begin
                    if (Q == TOP) begin
                        evento = 1'b1;
                        q_nxt  = SAT ? Q : '0;
                    end else begin
                        q_nxt = Q + 1'b1;
                    end
                end else begin
                    if (Q == '0) begin
                        evento = 1'b1;
                        q_nxt  = SAT ? Q : TOP;
                    end else begin
                        q_nxt = Q - 1'b1;
                    end
                end
            end
            // A wrap/saturation attempt on the same edge beats the flag clear.
            if (evento) begin
                flag_nxt = 1'b1;
            end else if (limpa_flag) begin
                flag_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q       <= RST_VAL;
            estouro <= 1'b0;
        end else begin
            Q       <= q_nxt;
            estouro <= flag_nxt;
        end
    end

    assign rco = conta & ((~desce & (Q == TOP)) | (desce & (Q == '0)));

endmodule

// File: tb/tb_contador_ud_mod.sv
// Directed bench for contador_ud_mod: default, offset-reset, wrap, saturate and a
// two-stage decimal cascade, all with hand-computed expectations.
module tb_contador_ud_mod;

    logic       clock;
    logic       reset;
    logic       zera;
    logic       carrega;
    logic [3:0] d;
    logic       conta;
    logic       desce;
    logic       limpa_flag;
    logic       casc_en;

    logic [3:0] def_q, rv_q, w10_q, s10_q, lo_q, hi_q;
    logic       def_rco, rv_rco, w10_rco, s10_rco, lo_rco, hi_rco;
    logic       def_est, rv_est, w10_est, s10_est, lo_est, hi_est;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];

    contador_ud_mod u_def (
        .clock(clock), .reset(reset), .zera(zera), .carrega(carrega), .D(d),
        .conta(conta), .desce(desce), .limpa_flag(limpa_flag),
        .Q(def_q), .rco(def_rco), .estouro(def_est)
    );

    contador_ud_mod #(.MODULO(10), .RESET_VALUE(3)) u_rv (
        .clock(clock), .reset(reset), .zera(zera), .carrega(carrega), .D(d),
        .conta(conta), .desce(desce), .limpa_flag(limpa_flag),
        .Q(rv_q), .rco(rv_rco), .estouro(rv_est)
    );

    contador_ud_mod #(.MODULO(10)) u_w10 (
        .clock(clock), .reset(reset), .zera(zera), .carrega(carrega), .D(d),
        .conta(conta), .desce(desce), .limpa_flag(limpa_flag),
        .Q(w10_q), .rco(w10_rco), .estouro(w10_est)
    );

    contador_ud_mod #(.MODULO(10), .SATURATE(1)) u_s10 (
        .clock(clock), .reset(reset), .zera(zera), .carrega(carrega), .D(d),
        .conta(conta), .desce(desce), .limpa_flag(limpa_flag),
        .Q(s10_q), .rco(s10_rco), .estouro(s10_est)
    );

    contador_ud_mod #(.MODULO(10)) u_lo (
        .clock(clock), .reset(reset), .zera(1'b0), .carrega(1'b0), .D(4'd0),
        .conta(casc_en), .desce(1'b0), .limpa_flag(1'b0),
        .Q(lo_q), .rco(lo_rco), .estouro(lo_est)
    );

    contador_ud_mod #(.MODULO(10)) u_hi (
        .clock(clock), .reset(reset), .zera(1'b0), .carrega(1'b0), .D(4'd0),
        .conta(lo_rco), .desce(1'b0), .limpa_flag(1'b0),
        .Q(hi_q), .rco(hi_rco), .estouro(hi_est)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ctrl(input logic z, input logic c, input logic [3:0] dv,
                            input logic en, input logic dn, input logic lf);
        zera       = z;
        carrega    = c;
        d          = dv;
        conta      = en;
        desce      = dn;
        limpa_flag = lf;
    endtask

    initial begin
        logic [3:0] exp_rco [4];
        logic [3:0] exp_est [4];
        reset   = 1'b1;
        casc_en = 1'b0;
        set_ctrl(0, 0, 4'd0, 0, 0, 0);
        #12;
        check("reset_def_q", 32'(def_q), 0);
        check("reset_def_est", 32'(def_est), 0);
        check("reset_rv_q", 32'(rv_q), 3);
        check("reset_def_rco", 32'(def_rco), 0);
        reset = 1'b0;

        // 1: asynchronous reset mid-count
        set_ctrl(0, 0, 4'd0, 1, 0, 0);
        repeat (7) tick();
        check("t1_def_q7", 32'(def_q), 7);
        #2 reset = 1'b1;
        conta = 1'b0;
        #1;
        check("t1_async_q", 32'(def_q), 0);
        check("t1_async_est", 32'(def_est), 0);
        check("t1_async_rv_q", 32'(rv_q), 3);
        #1 reset = 1'b0;

        // 2: modulo-10 up count with wrap
        set_ctrl(0, 0, 4'd0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t2_q_%0d", k), 32'(w10_q), k);
            check($sformatf("t2_rco_%0d", k), 32'(w10_rco), (k == 9) ? 1 : 0);
            check($sformatf("t2_est_%0d", k), 32'(w10_est), 0);
            tick();
        end
        check("t2_wrap_q", 32'(w10_q), 0);
        check("t2_wrap_est", 32'(w10_est), 1);
        check("t2_sat_q", 32'(s10_q), 9);
        check("t2_sat_est", 32'(s10_est), 1);
        check("t2_sat_rco", 32'(s10_rco), 1);

        // 3: saturating down count from a load of 2
        set_ctrl(1, 0, 4'd0, 0, 0, 0);
        tick();
        set_ctrl(0, 1, 4'd2, 0, 0, 0);
        tick();
        check("t3_load_q", 32'(s10_q), 2);
        check("t3_load_est", 32'(s10_est), 0);
        set_ctrl(0, 0, 4'd0, 1, 1, 0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd0);
        exp_rco = '{4'd0, 4'd0, 4'd1, 4'd1};
        exp_est = '{4'd0, 4'd0, 4'd1, 4'd1};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_rco_%0d", i), 32'(s10_rco), 32'(exp_rco[i]));
            tick();
            check($sformatf("t3_q_%0d", i), 32'(s10_q), 32'(exp_q.pop_front()));
            check($sformatf("t3_est_%0d", i), 32'(s10_est), 32'(exp_est[i]));
        end
        check("t3_w10_q", 32'(w10_q), 8);
        check("t3_w10_est", 32'(w10_est), 1);
        conta = 1'b0;
        #1;
        check("t3_rco_gated", 32'(s10_rco), 0);

        // 4: load clamp and zera-over-carrega priority
        set_ctrl(0, 1, 4'd13, 0, 0, 0);
        tick();
        check("t4_clamp13_q", 32'(w10_q), 9);
        check("t4_clamp_est_kept", 32'(w10_est), 1);
        check("t4_def_load13", 32'(def_q), 13);
        d = 4'd3;
        tick();
        check("t4_load3_q", 32'(w10_q), 3);
        d = 4'd10;
        tick();
        check("t4_clamp10_q", 32'(w10_q), 9);
        set_ctrl(1, 1, 4'd5, 0, 0, 0);
        tick();
        check("t4_zera_q", 32'(w10_q), 0);
        check("t4_zera_est", 32'(w10_est), 0);
        check("t4_zera_def_q", 32'(def_q), 0);

        // 5: flag clear versus same-edge wrap
        set_ctrl(0, 1, 4'd9, 0, 0, 0);
        tick();
        set_ctrl(0, 0, 4'd0, 1, 0, 1);
        tick();
        check("t5_wrap_lf_q", 32'(w10_q), 0);
        check("t5_wrap_lf_est", 32'(w10_est), 1);
        set_ctrl(0, 0, 4'd0, 0, 0, 1);
        tick();
        check("t5_clear_q", 32'(w10_q), 0);
        check("t5_clear_est", 32'(w10_est), 0);
        set_ctrl(0, 0, 4'd0, 1, 1, 0);
        tick();
        check("t5_down_wrap_q", 32'(w10_q), 9);
        check("t5_down_wrap_est", 32'(w10_est), 1);
        set_ctrl(0, 1, 4'd4, 1, 1, 1);
        tick();
        check("t5_load_prio_q", 32'(w10_q), 4);
        check("t5_load_lf_est", 32'(w10_est), 0);
        set_ctrl(0, 0, 4'd0, 0, 0, 0);

        // 6: two-digit decimal cascade
        check("t6_start", 32'({hi_q, lo_q}), 0);
        casc_en = 1'b1;
        repeat (37) tick();
        check("t6_37", 32'({hi_q, lo_q}), 32'h37);
        repeat (62) tick();
        check("t6_99", 32'({hi_q, lo_q}), 32'h99);
        check("t6_99_hi_est", 32'(hi_est), 0);
        check("t6_99_lo_est", 32'(lo_est), 1);
        check("t6_99_lo_rco", 32'(lo_rco), 1);
        check("t6_99_hi_rco", 32'(hi_rco), 1);
        tick();
        check("t6_100", 32'({hi_q, lo_q}), 0);
        check("t6_100_hi_est", 32'(hi_est), 1);
        check("t6_100_lo_est", 32'(lo_est), 1);
        casc_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
